// File: rtl/seg7_scan_if.sv
// seg7_scan_if -- control/data bundle between the segment-code source
// (master) and the multiplexed 7-segment scanner (slave).
interface seg7_scan_if;
  logic       en;
  logic       wr;
  logic [1:0] digit_sel;
  logic [7:0] seg_in;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_pulse;

  modport master (
    output en,
    output wr,
    output digit_sel,
    output seg_in,
    input  seg,
    input  an,
    input  frame_pulse
  );

  modport slave (
    input  en,
    input  wr,
    input  digit_sel,
    input  seg_in,
    output seg,
    output an,
    output frame_pulse
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan -- 4-digit multiplexed 7-segment display scanner.
// Holds four active-low segment codes, cycles through the digits every
// REFRESH_DIV clocks and drives registered an/seg outputs, with a one-cycle
// frame_pulse once each full scan has been shown.
// Optional feature: define SEG7_SCAN_BLANK_EN to blank leading zero digits
// (digits 3..1 showing 8'hC0 with only zeros above them are driven dark).
module seg7_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan_if.slave   bus
);

  localparam logic [19:0] PRESC_LAST = 20'(REFRESH_DIV - 32'd1);
  localparam logic [7:0]  SEG_ZERO   = 8'hC0;
  localparam logic [7:0]  SEG_DARK   = 8'hFF;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  logic [19:0] presc_r;
  logic [1:0]  index_r;
  logic [7:0]  entry_r [4];
  logic        frame_pend_r;
  logic [7:0]  seg_r;
  logic [3:0]  an_r;
  logic        frame_pulse_r;

  logic        tick_s;
  logic [3:0]  blank_s;
  logic [7:0]  shown_s;
  logic [3:0]  an_s;

  // Slot tick: prescaler reached its last count while scanning is enabled.
  always_comb begin
    tick_s = 1'b0;
    if (bus.en && (presc_r == PRESC_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Leading-zero blank mask; digit 0 is never blanked.
  always_comb begin
    blank_s = 4'b0000;
`ifdef SEG7_SCAN_BLANK_EN
    blank_s[3] = (entry_r[3] == SEG_ZERO);
    blank_s[2] = blank_s[3] && (entry_r[2] == SEG_ZERO);
    blank_s[1] = blank_s[2] && (entry_r[1] == SEG_ZERO);
`else
    blank_s = 4'b0000;
`endif
  end

  // Select the code and the one-hot anode for the current scan index.
  always_comb begin
    shown_s = SEG_DARK;
    an_s    = AN_OFF;
    case (index_r)
      2'd0: begin
        shown_s = entry_r[0];
        an_s    = 4'b1110;
      end
      2'd1: begin
        shown_s = entry_r[1];
        an_s    = 4'b1101;
      end
      2'd2: begin
        shown_s = entry_r[2];
        an_s    = 4'b1011;
      end
      2'd3: begin
        shown_s = entry_r[3];
        an_s    = 4'b0111;
      end
      default: begin
        shown_s = SEG_DARK;
        an_s    = AN_OFF;
      end
    endcase
    if (blank_s[index_r]) begin
      shown_s = SEG_DARK;
    end else begin
      shown_s = shown_s;
    end
  end

  // Digit register file; writes are accepted whether or not scanning runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        entry_r[k] <= SEG_DARK;
      end
    end else if (bus.wr) begin
      entry_r[bus.digit_sel] <= bus.seg_in;
    end else begin
      for (int k = 0; k < 4; k++) begin
        entry_r[k] <= entry_r[k];
      end
    end
  end

  // Prescaler and scan index; both freeze while scanning is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= 20'd0;
      index_r <= 2'd0;
    end else if (tick_s) begin
      presc_r <= 20'd0;
      index_r <= index_r + 2'd1;
    end else if (bus.en) begin
      presc_r <= presc_r + 20'd1;
      index_r <= index_r;
    end else begin
      presc_r <= presc_r;
      index_r <= index_r;
    end
  end

  // Frame pulse follows the last digit's slot by one edge so it lines up
  // with the first cycle of the next scan on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_pend_r  <= 1'b0;
      frame_pulse_r <= 1'b0;
    end else if (bus.en) begin
      frame_pend_r  <= tick_s && (index_r == 2'd3);
      frame_pulse_r <= frame_pend_r;
    end else begin
      frame_pend_r  <= frame_pend_r;
      frame_pulse_r <= 1'b0;
    end
  end

  // Registered display drive; dark while disabled or in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_DARK;
    end else if (bus.en) begin
      an_r  <= an_s;
      seg_r <= shown_s;
    end else begin
      an_r  <= AN_OFF;
      seg_r <= SEG_DARK;
    end
  end

  assign bus.an          = an_r;
  assign bus.seg         = seg_r;
  assign bus.frame_pulse = frame_pulse_r;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan -- scoreboard bench for seg7_scan.
// dut_a runs with REFRESH_DIV=4, dut_b with REFRESH_DIV=1 (write/tick collision).
module tb_seg7_scan;

  logic clk;
  logic rst_a;
  logic rst_b;

  seg7_scan_if bus_a ();
  seg7_scan_if bus_b ();

  seg7_scan #(.REFRESH_DIV(4)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  seg7_scan #(.REFRESH_DIV(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEG7_SCAN_BLANK_EN
  localparam logic [7:0] EXP_D3 = 8'hFF;
  localparam logic [7:0] EXP_D2 = 8'hFF;
`else
  localparam logic [7:0] EXP_D3 = 8'hC0;
  localparam logic [7:0] EXP_D2 = 8'hC0;
`endif

  typedef struct {
    int         d;
    int         ph;
    logic [3:0] an;
    logic [7:0] seg;
    logic       fp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // One clock of stimulus on DUT d, plus the outputs expected after this edge.
  task automatic cyc(input int d, input int ph, input logic r, input logic e,
                     input logic w, input logic [1:0] s, input logic [7:0] v,
                     input logic [3:0] ean, input logic [7:0] eseg, input logic efp);
    exp_t x;
    if (d == 0) begin
      rst_a = r; bus_a.en = e; bus_a.wr = w; bus_a.digit_sel = s; bus_a.seg_in = v;
    end else begin
      rst_b = r; bus_b.en = e; bus_b.wr = w; bus_b.digit_sel = s; bus_b.seg_in = v;
    end
    x.d = d; x.ph = ph; x.an = ean; x.seg = eseg; x.fp = efp;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // n enabled cycles on dut_a showing one digit; fp expected only on the first.
  task automatic slot(input int ph, input logic [3:0] ean, input logic [7:0] eseg,
                      input logic fp_first, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, ph, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, ean, eseg, (i == 0) ? fp_first : 1'b0);
    end
  endtask

  // Monitor: pop one expectation per edge and compare against the chosen DUT.
  initial begin
    exp_t       x;
    logic [3:0] g_an;
    logic [7:0] g_seg;
    logic       g_fp;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        if (x.d == 0) begin
          g_an = bus_a.an; g_seg = bus_a.seg; g_fp = bus_a.frame_pulse;
        end else begin
          g_an = bus_b.an; g_seg = bus_b.seg; g_fp = bus_b.frame_pulse;
        end
        checks++;
        if (g_an !== x.an || g_seg !== x.seg || g_fp !== x.fp) begin
          errors++;
          $display("FAIL dut%0d_phase%0d t=%0t an/seg/fp got %b/%h/%b expected %b/%h/%b",
                   x.d, x.ph, $time, g_an, g_seg, g_fp, x.an, x.seg, x.fp);
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.en = 1'b0; bus_a.wr = 1'b0; bus_a.digit_sel = 2'd0; bus_a.seg_in = 8'h00;
    bus_b.en = 1'b0; bus_b.wr = 1'b0; bus_b.digit_sel = 2'd0; bus_b.seg_in = 8'h00;

    // Reset, with a write that must be discarded.
    cyc(0, 1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 4'b1111, 8'hFF, 1'b0);
    cyc(0, 1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 8'hFF, 1'b0);

    // First scan after reset: blank codes, 4 cycles per digit.
    slot(2, 4'b1110, 8'hFF, 1'b0, 4);
    slot(2, 4'b1101, 8'hFF, 1'b0, 4);
    slot(2, 4'b1011, 8'hFF, 1'b0, 4);
    slot(2, 4'b0111, 8'hFF, 1'b0, 4);

    // Load digits while scanning; digit 0 is active so F9 appears one edge later.
    cyc(0, 3, 1'b0, 1'b1, 1'b1, 2'd0, 8'hF9, 4'b1110, 8'hFF, 1'b1);
    cyc(0, 3, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA4, 4'b1110, 8'hF9, 1'b0);
    cyc(0, 3, 1'b0, 1'b1, 1'b1, 2'd2, 8'hB0, 4'b1110, 8'hF9, 1'b0);
    cyc(0, 3, 1'b0, 1'b1, 1'b1, 2'd3, 8'h99, 4'b1110, 8'hF9, 1'b0);
    slot(3, 4'b1101, 8'hA4, 1'b0, 4);
    slot(3, 4'b1011, 8'hB0, 1'b0, 4);
    slot(3, 4'b0111, 8'h99, 1'b0, 4);
    slot(3, 4'b1110, 8'hF9, 1'b1, 4);
    slot(3, 4'b1101, 8'hA4, 1'b0, 4);
    slot(3, 4'b1011, 8'hB0, 1'b0, 4);
    slot(3, 4'b0111, 8'h99, 1'b0, 4);

    // Enable gap in the middle of slot 2, with a write to digit 3 during the gap.
    slot(4, 4'b1110, 8'hF9, 1'b1, 4);
    slot(4, 4'b1101, 8'hA4, 1'b0, 4);
    slot(4, 4'b1011, 8'hB0, 1'b0, 2);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 4, 1'b0, 1'b0, (i == 3), 2'd3, 8'h82, 4'b1111, 8'hFF, 1'b0);
    end
    slot(4, 4'b1011, 8'hB0, 1'b0, 2);
    slot(4, 4'b0111, 8'h82, 1'b0, 4);

    // Reset on the edge where slot 3 would tick: no frame pulse follows.
    slot(5, 4'b1110, 8'hF9, 1'b1, 4);
    slot(5, 4'b1101, 8'hA4, 1'b0, 4);
    slot(5, 4'b1011, 8'hB0, 1'b0, 4);
    slot(5, 4'b0111, 8'h82, 1'b0, 3);
    cyc(0, 5, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 8'hFF, 1'b0);
    slot(5, 4'b1110, 8'hFF, 1'b0, 4);
    slot(5, 4'b1101, 8'hFF, 1'b0, 4);
    slot(5, 4'b1011, 8'hFF, 1'b0, 4);
    slot(5, 4'b0111, 8'hFF, 1'b0, 4);
    slot(5, 4'b1110, 8'hFF, 1'b1, 1);

    // Leading-zero pattern {C0,C0,F9,C0} for digits 3..0, loaded while disabled.
    cyc(0, 6, 1'b0, 1'b0, 1'b1, 2'd0, 8'hC0, 4'b1111, 8'hFF, 1'b0);
    cyc(0, 6, 1'b0, 1'b0, 1'b1, 2'd1, 8'hF9, 4'b1111, 8'hFF, 1'b0);
    cyc(0, 6, 1'b0, 1'b0, 1'b1, 2'd2, 8'hC0, 4'b1111, 8'hFF, 1'b0);
    cyc(0, 6, 1'b0, 1'b0, 1'b1, 2'd3, 8'hC0, 4'b1111, 8'hFF, 1'b0);
    slot(6, 4'b1110, 8'hC0, 1'b0, 3);
    slot(6, 4'b1101, 8'hF9, 1'b0, 4);
    slot(6, 4'b1011, EXP_D2, 1'b0, 4);
    slot(6, 4'b0111, EXP_D3, 1'b0, 4);
    slot(6, 4'b1110, 8'hC0, 1'b1, 1);

    // REFRESH_DIV=1: write digit 1 on the edge its slot starts on the outputs.
    cyc(1, 7, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 8'hFF, 1'b0);
    cyc(1, 7, 1'b0, 1'b0, 1'b1, 2'd1, 8'hA4, 4'b1111, 8'hFF, 1'b0);
    cyc(1, 7, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1110, 8'hFF, 1'b0);
    cyc(1, 7, 1'b0, 1'b1, 1'b1, 2'd1, 8'h92, 4'b1101, 8'hA4, 1'b0);
    cyc(1, 7, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1011, 8'hFF, 1'b0);
    cyc(1, 7, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0111, 8'hFF, 1'b0);
    cyc(1, 7, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1110, 8'hFF, 1'b1);
    cyc(1, 7, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1101, 8'h92, 1'b0);
    cyc(1, 7, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1011, 8'hFF, 1'b0);
    cyc(1, 7, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0111, 8'hFF, 1'b0);
    cyc(1, 7, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1110, 8'hFF, 1'b1);

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain leftover %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is driven per scan slot (legal range 1..2^20).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  scan enable; 0 blanks the display and freezes scanning.
REQ-005 SHALL have port wr  input  1  write strobe for one digit's segment code.
REQ-006 SHALL have port digit_sel  input  2  digit index written when wr=1 (0 = rightmost).
REQ-007 SHALL have port seg_in  input  8  active-low segment code {dp,g,f,e,d,c,b,a} from the upstream BCD-to-7-segment counter.
REQ-008 SHALL have port seg  output  8  registered active-low segment drive for the currently selected digit.
REQ-009 SHALL have port an  output  4  registered active-low one-hot digit enable.
REQ-010 SHALL have port frame_pulse  output  1  one-cycle high pulse at the end of each full 4-digit scan.

Function
REQ-011 SHALL hold a 4 x 8-bit digit register file; wr=1 loads seg_in into entry digit_sel at the clock edge where wr is sampled.
REQ-012 SHALL run a prescaler counting 0..REFRESH_DIV-1 while en=1, asserting an internal tick when it equals REFRESH_DIV-1 and wrapping to 0 on the same edge.
REQ-013 SHALL advance the 2-bit digit index 0->1->2->3->0 on each tick; REFRESH_DIV=1 gives a tick every cycle.
REQ-014 SHALL register outputs every cycle while en=1: an <= ~(1 << index), seg <= entry[index].
REQ-015 SHALL present a written code on seg two clock edges after wr is sampled when the written digit is the active one (no write-to-output bypass).
REQ-016 SHALL, on simultaneous wr and tick, perform both the write and the index advance on that edge.
REQ-017 SHALL assert frame_pulse for exactly one cycle, registered, on the edge after a tick occurs with index = 3.
REQ-018 SHALL, while en=0, hold prescaler and index, drive an = 4'b1111, seg = 8'hFF and frame_pulse = 0; writes still update the register file.
REQ-019 SHALL, when en returns to 1, resume from the held prescaler value and index without a skipped or repeated slot.

Reset
REQ-020 SHALL, when rst=1 at a clock edge, clear prescaler to 0, index to 0, all register-file entries to 8'hFF, an to 4'b1111, seg to 8'hFF, frame_pulse to 0.
REQ-021 SHALL give rst priority over wr and en; a write in a reset cycle is discarded.
REQ-022 SHALL begin driving digit 0 (an = 4'b1110) on the first edge after rst deasserts with en=1.

Configuration
REQ-023 SHALL implement leading-zero blanking only when SEG7_SCAN_BLANK_EN is defined: entry k (k = 3,2,1) is output as 8'hFF if it and every higher entry equal 8'hC0 (decimal zero, dp off); entry 0 is never blanked.
REQ-024 SHALL, without SEG7_SCAN_BLANK_EN, output register-file contents unmodified.

Verification
REQ-025 Reset: REFRESH_DIV=4, rst=1 two cycles then en=1 -> an=4'b1110, seg=8'hFF; an steps 1110,1101,1011,0111 every 4 cycles.
REQ-026 Write/scan: write 8'hF9,8'hA4,8'hB0,8'h99 to digits 0..3 -> seg shows F9,A4,B0,99 in slots 0..3; frame_pulse once per 16 cycles, one cycle wide, after slot 3 ends.
REQ-027 Collision: REFRESH_DIV=1, wr to digit 1 with 8'h92 on tick edge entering slot 1 -> old entry shown that slot, 8'h92 on next visit to slot 1.
REQ-028 Enable gap: drop en for 10 cycles mid-slot 2 -> an=4'b1111, seg=8'hFF, no frame_pulse; on re-enable slot 2 completes its remaining cycles.
REQ-029 Blanking (macro defined): entries {C0,C0,F9,C0} for digits 3..0 -> digits 3,2 show 8'hFF, digit 1 F9, digit 0 C0; macro undefined -> all four shown raw.
REQ-030 Mid-operation reset: assert rst during slot 3 with pending tick -> no frame_pulse, all entries 8'hFF, scan restarts at digit 0.
